// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - single-outstanding request/response memory with fixed latency and address checking
module mem_responder #(
    parameter int LATENCY     = 2,
    parameter int DEPTH_WORDS = 64
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    input  logic        req_wr_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        req_ready_o,
    output logic        rsp_valid_o,
    output logic [31:0] rdata_o,
    output logic        addr_err_o
);

    localparam int          IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);
    localparam logic [3:0]  LAT        = 4'(LATENCY);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               wr_q, wr_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;
    logic [31:0]        mem_q [DEPTH_WORDS];

    logic               enter_resp;
    logic               mem_we;
    logic               cur_wr;
    logic               cur_err;
    logic [31:0]        cur_addr;
    logic [31:0]        cur_wdata;
    logic [IDX_W-1:0]   cur_idx;

    // With zero latency the request enters RESP straight from IDLE, so the
    // response must be computed from the live inputs rather than the latches.
    always_comb begin
        cur_addr  = (state_q == IDLE) ? addr_i   : addr_q;
        cur_wdata = (state_q == IDLE) ? wdata_i  : wdata_q;
        cur_wr    = (state_q == IDLE) ? req_wr_i : wr_q;
        cur_err   = (cur_addr[1:0] != 2'b00) || (cur_addr >= ADDR_LIMIT);
        cur_idx   = cur_addr[IDX_W+1:2];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wr_d       = wr_q;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    wr_d    = req_wr_i;
                    cnt_d   = LAT;
                    if (LAT == 4'd0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        mem_we  = enter_resp && cur_wr && !cur_err;
        err_d   = enter_resp && cur_err;
        rdata_d = '0;
        if (enter_resp && !cur_wr && !cur_err) begin
            rdata_d = mem_q[cur_idx];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Writes commit on the edge entering RESP, before any later acceptance,
    // so a following read sees the new data without a bypass path.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[cur_idx] <= cur_wdata;
        end
    end

    assign req_ready_o = (state_q == IDLE);
    assign rsp_valid_o = (state_q == RESP);
    assign rdata_o     = (state_q == RESP) ? rdata_q : 32'h0;
    assign addr_err_o  = (state_q == RESP) ? err_q   : 1'b0;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder at LATENCY 0 and 2
module tb_mem_responder;

    logic        clk;
    logic        rst_n;
    logic        rv0, rv2;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rdy0, rdy2;
    logic        rsp0, rsp2;
    logic [31:0] rd0, rd2;
    logic        err0, err2;

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        q0[$];
    exp_t        q2[$];
    logic [31:0] mdl_mem [64];
    int          cyc;
    int          n_pass;
    int          n_total;

    mem_responder #(.LATENCY(0), .DEPTH_WORDS(64)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(rv0), .req_wr_i(wr),
        .addr_i(addr), .wdata_i(wdata), .req_ready_o(rdy0), .rsp_valid_o(rsp0),
        .rdata_o(rd0), .addr_err_o(err0)
    );

    mem_responder #(.LATENCY(2), .DEPTH_WORDS(64)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(rv2), .req_wr_i(wr),
        .addr_i(addr), .wdata_i(wdata), .req_ready_o(rdy2), .rsp_valid_o(rsp2),
        .rdata_o(rd2), .addr_err_o(err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rsp0) begin
            if (q0.size() == 0) cmp("d0_unexpected_rsp", 32'd1, 32'd0);
            else begin
                e = q0.pop_front();
                cmp("d0_rsp_cycle", cyc, e.cyc);
                cmp("d0_rdata", rd0, e.rdata);
                cmp("d0_addr_err", {31'd0, err0}, {31'd0, e.err});
            end
        end else begin
            cmp("d0_quiet_outputs", rd0 | {31'd0, err0}, 32'd0);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rsp2) begin
            if (q2.size() == 0) cmp("d2_unexpected_rsp", 32'd1, 32'd0);
            else begin
                e = q2.pop_front();
                cmp("d2_rsp_cycle", cyc, e.cyc);
                cmp("d2_rdata", rd2, e.rdata);
                cmp("d2_addr_err", {31'd0, err2}, {31'd0, e.err});
            end
        end else begin
            cmp("d2_quiet_outputs", rd2 | {31'd0, err2}, 32'd0);
        end
    end

    task automatic wait_ready(input bit d0, input bit d2);
        int n = 0;
        while (!((!d0 || rdy0) && (!d2 || rdy2)) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) cmp("ready_timeout", 32'd0, 32'd1);
    endtask

    // Expected response straight from the behavioural rules; acceptance happens
    // on the next rising edge, response appears LATENCY+1 edges after issue.
    task automatic issue(input bit d0, input bit d2, input bit p2, input bit w,
                         input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        wait_ready(d0, d2);
        wr = w; addr = a; wdata = wd; rv0 = d0; rv2 = d2;
        if (a[1:0] != 2'b00 || a >= 32'd256) begin
            e.rdata = 32'h0; e.err = 1'b1;
        end else if (w) begin
            mdl_mem[a[7:2]] = wd;
            e.rdata = 32'h0; e.err = 1'b0;
        end else begin
            e.rdata = mdl_mem[a[7:2]]; e.err = 1'b0;
        end
        if (d0) begin e.cyc = cyc + 1; q0.push_back(e); end
        if (d2 && p2) begin e.cyc = cyc + 3; q2.push_back(e); end
        @(negedge clk);
        rv0 = 1'b0; rv2 = 1'b0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 64; i++) mdl_mem[i] = 32'h0;
    endtask

    initial begin
        logic [31:0] a;
        int          sel;
        int          c;
        exp_t        e;
        int          n;
        n_pass = 0; n_total = 0;
        rst_n = 1'b0; rv0 = 1'b0; rv2 = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        clear_model();
        repeat (3) @(negedge clk);
        cmp("reset_ready0", {31'd0, rdy0}, 32'd1);
        cmp("reset_ready2", {31'd0, rdy2}, 32'd1);
        cmp("reset_rsp", {30'd0, rsp0, rsp2}, 32'd0);

        // first request on the first edge after release
        rst_n = 1'b1;
        issue(1, 1, 1, 0, 32'h0, 32'h0);
        cmp("d0_ready_busy", {31'd0, rdy0}, 32'd0);
        cmp("d2_ready_busy", {31'd0, rdy2}, 32'd0);
        @(negedge clk);
        cmp("d0_ready_back", {31'd0, rdy0}, 32'd1);
        cmp("d2_ready_still_busy", {31'd0, rdy2}, 32'd0);

        issue(1, 1, 1, 1, 32'h10, 32'hDEADBEEF);
        issue(1, 1, 1, 0, 32'h10, 32'h0);
        issue(1, 1, 1, 1, 32'h6, 32'h1234);
        issue(1, 1, 1, 0, 32'h4, 32'h0);
        issue(1, 1, 1, 0, 32'h100, 32'h0);
        issue(1, 1, 1, 0, 32'hFC, 32'h0);
        issue(1, 1, 1, 1, 32'h8000_0010, 32'h1111_2222);
        issue(1, 1, 1, 0, 32'h10, 32'h0);

        // request held for six cycles: only two acceptances on the LATENCY=2 unit
        wait_ready(1, 1);
        c = cyc;
        wr = 1'b0; addr = 32'h10; rv2 = 1'b1;
        e.rdata = mdl_mem[4]; e.err = 1'b0;
        e.cyc = c + 3; q2.push_back(e);
        e.cyc = c + 7; q2.push_back(e);
        repeat (6) @(negedge clk);
        rv2 = 1'b0;

        for (int k = 0; k < 200; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            sel = $urandom_range(0, 9);
            if (sel <= 5)      a = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
            else if (sel <= 7) a = {24'd0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
            else if (sel == 8) a = 32'($urandom_range(256, 4095));
            else               a = {1'b1, 23'd0, 6'($urandom_range(0, 63)), 2'b00};
            issue(1, 1, 1, 1'($urandom_range(0, 1)), a, $urandom);
        end

        // write aborted by reset while the LATENCY=2 unit is still waiting
        issue(1, 1, 0, 1, 32'h8, 32'hA5A5A5A5);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        clear_model();
        rst_n = 1'b1;
        issue(1, 1, 1, 0, 32'h8, 32'h0);
        issue(1, 1, 1, 0, 32'h10, 32'h0);

        n = 0;
        while ((q0.size() != 0 || q2.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        cmp("d0_drain", q0.size(), 32'd0);
        cmp("d2_drain", q2.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter LATENCY, default 2, meaning wait cycles between request acceptance and response; legal range 0..15.
REQ-002 Parameter DEPTH_WORDS, default 64, meaning number of 32-bit storage words; power of two, 4..256.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 req_valid  input  1  CPU presents a request this cycle.
REQ-006 req_wr  input  1  request type; 0 = read, 1 = write.
REQ-007 addr  input  32  byte address of the request.
REQ-008 wdata  input  32  write data, used only when req_wr = 1.
REQ-009 req_ready  output  1  responder can accept a request this cycle.
REQ-010 rsp_valid  output  1  one-cycle pulse; response fields valid.
REQ-011 rdata  output  32  read data; 0 for writes and errors.
REQ-012 addr_err  output  1  qualified by rsp_valid; request was misaligned or out of range.

Function
REQ-013 FSM states: IDLE, WAIT, RESP.
REQ-014 req_ready = 1 only in IDLE; handshake completes on the rising edge where req_valid = 1 and req_ready = 1.
REQ-015 On acceptance: latch addr, req_wr, wdata; load wait counter with LATENCY.
REQ-016 Transition on acceptance: IDLE -> WAIT if LATENCY > 0; IDLE -> RESP if LATENCY = 0.
REQ-017 In WAIT: decrement counter each cycle; WAIT -> RESP on the cycle the counter is 1.
REQ-018 Acceptance-to-rsp_valid latency is exactly LATENCY+1 cycles.
REQ-019 In RESP: rsp_valid = 1 for exactly one cycle; RESP -> IDLE unconditionally.
REQ-020 req_valid in WAIT or RESP is ignored; no queuing, and latched fields do not change.
REQ-021 Error condition: latched addr[1:0] != 0, or latched addr >= 4*DEPTH_WORDS.
REQ-022 On error: addr_err = 1, rdata = 0, and storage is unmodified.
REQ-023 Valid write: storage[addr >> 2] <= wdata on the edge entering RESP; rdata = 0.
REQ-024 Valid read: rdata = storage[addr >> 2], sampled on the edge entering RESP.
REQ-025 A read following a write to the same word returns the new data; no bypass is needed, because the write commits before the next acceptance.
REQ-026 Outside RESP: rsp_valid = 0, addr_err = 0, rdata = 0.
REQ-027 Address width for indexing is log2(DEPTH_WORDS) bits taken from addr[...:2].
REQ-028 The range check uses full 32-bit addr; upper bits are not ignored, so there is no aliasing.

Reset
REQ-029 While reset = 0, asynchronously force: state IDLE, counter 0, latched fields 0, req_ready = 1 after release, rsp_valid = 0, rdata = 0, addr_err = 0.
REQ-030 While reset = 0, clear all storage words to 0.
REQ-031 Reset asserted mid-WAIT or in RESP aborts the request. A pending write that has not yet reached RESP is not committed, and no rsp_valid is emitted.
REQ-032 The first acceptance is possible on the first rising edge after reset goes high.

Verification
REQ-033 LATENCY=2: write addr=0x10, wdata=0xDEADBEEF accepted at cycle 0 -> rsp_valid at cycle 3, addr_err=0, rdata=0. Then read 0x10 -> rdata=0xDEADBEEF, rsp_valid 3 cycles after acceptance.
REQ-034 LATENCY=0: read 0x0 after reset -> rsp_valid on the next cycle, rdata=0, req_ready low for exactly 1 cycle.
REQ-035 Misaligned write addr=0x6 with wdata=0x1234 -> addr_err=1, rdata=0. A subsequent read of 0x4 returns 0.
REQ-036 Out of range with DEPTH_WORDS=64: read addr=0x100 -> addr_err=1. Read addr=0xFC -> addr_err=0.
REQ-037 req_valid held high for 6 consecutive cycles with LATENCY=2 -> exactly 2 acceptances, at cycles 0 and 4, and 2 rsp_valid pulses, at cycles 3 and 7.
REQ-038 Write 0xA5A5A5A5 to 0x8, then reset asserted during WAIT -> no rsp_valid. After release, a read of 0x8 returns 0.
